// File: rtl/adc_pkg.sv
// Shared definitions for the serial-ADC voltmeter: FSM states, result widths
// and the BCD-digit to ASCII helper.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CONV_WAIT,
    ST_SCALE,
    ST_BCD,
    ST_OUT_HOLD
  } adc_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam int         MV_W       = 14;
  localparam int         BCD_DIGITS = 4;

  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: converts an MV_W-bit binary value to BCD_DIGITS
// packed BCD digits, one input bit per clock, pulsing done when complete.
module bin2bcd_seq
  import adc_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [MV_W-1:0]         bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int            CW   = $clog2(MV_W + 1);
  localparam logic [CW-1:0] LAST = CW'(MV_W - 1);

  logic [MV_W-1:0]              sh;
  logic [CW-1:0]                cnt;
  logic                         running;
  logic [4*BCD_DIGITS-1:0]      adj;
  logic [4*BCD_DIGITS+MV_W-1:0] dd_next;

  always_comb begin
    adj = bcd;
    for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    // Adjust then shift the combined {bcd, binary} register left by one.
    dd_next = {adj, sh} << 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh      <= '0;
      bcd     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh      <= bin;
        bcd     <= '0;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        {bcd, sh} <= dd_next;
        if (cnt == LAST) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/serial_adc_voltmeter.sv
// Serial-ADC voltmeter front end: CS/SCLK framing, dummy-frame discard,
// power-of-two averaging, mV scaling and ASCII result with valid/ready output.
module serial_adc_voltmeter
  import adc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CLK_DIV     = 250,
  parameter int CONV_CYCLES = 1000,
  parameter int AVG_LOG2    = 2,
  parameter int VREF_MV     = 5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cont_en,
  input  logic              adc_sdo,
  output logic              adc_sclk,
  output logic              adc_cs_n,
  output logic              busy,
  output logic [DATA_W-1:0] raw_avg,
  output logic [13:0]       mv,
  output logic [31:0]       ascii_out,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_MAX = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int NFRAMES = (1 << AVG_LOG2) + 1;
  localparam int FR_W    = $clog2(NFRAMES + 1);
  localparam int BIT_W   = $clog2(DATA_W + 1);
  localparam int ACC_W   = DATA_W + AVG_LOG2;
  localparam int PROD_W  = DATA_W + MV_W;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [FR_W-1:0]  FR_LAST   = FR_W'(NFRAMES);

  adc_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [FR_W-1:0]   frame_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] raw_hold;
  logic [MV_W-1:0]   mv_hold;
  logic              bcd_start;
  logic              bcd_done;
  logic [4*BCD_DIGITS-1:0] bcd_val;

  logic [DATA_W-1:0] raw_comb;
  logic [PROD_W-1:0] prod_comb;
  logic [MV_W-1:0]   mv_comb;
  logic [8*BCD_DIGITS-1:0] ascii_comb;

  always_comb begin
    raw_comb  = DATA_W'(acc >> AVG_LOG2);
    prod_comb = PROD_W'(raw_comb) * PROD_W'(VREF_MV);
    mv_comb   = MV_W'(prod_comb >> DATA_W);
    ascii_comb = '0;
    for (int unsigned d = 0; d < BCD_DIGITS; d++)
      ascii_comb[8*d +: 8] = bcd_to_ascii(bcd_val[4*d +: 4]);
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (bcd_start),
    .bin   (mv_hold),
    .done  (bcd_done),
    .bcd   (bcd_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      shift_reg <= '0;
      acc       <= '0;
      raw_hold  <= '0;
      mv_hold   <= '0;
      bcd_start <= 1'b0;
      adc_sclk  <= 1'b0;
      adc_cs_n  <= 1'b1;
      busy      <= 1'b0;
      raw_avg   <= '0;
      mv        <= '0;
      ascii_out <= {BCD_DIGITS{ASCII_ZERO}};
      out_valid <= 1'b0;
    end else begin
      bcd_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start || cont_en) begin
            state     <= ST_CS_SETUP;
            adc_cs_n  <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
            frame_cnt <= '0;
            acc       <= '0;
          end
        end

        ST_CS_SETUP: begin
          if (cnt == DIV_LAST) begin
            state     <= ST_SHIFT;
            cnt       <= '0;
            bit_cnt   <= '0;
            adc_sclk  <= 1'b1;
            shift_reg <= {shift_reg[DATA_W-2:0], adc_sdo};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + 1'b1;
          end else if (adc_sclk) begin
            cnt      <= '0;
            adc_sclk <= 1'b0;
          end else if (bit_cnt == BIT_LAST) begin
            // Frame 0 returns the previous conversion, so it never reaches the accumulator.
            state     <= ST_CONV_WAIT;
            cnt       <= '0;
            adc_cs_n  <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
            if (frame_cnt != '0)
              acc <= acc + ACC_W'(shift_reg);
          end else begin
            cnt       <= '0;
            bit_cnt   <= bit_cnt + 1'b1;
            adc_sclk  <= 1'b1;
            shift_reg <= {shift_reg[DATA_W-2:0], adc_sdo};
          end
        end

        ST_CONV_WAIT: begin
          if (cnt == CONV_LAST) begin
            cnt <= '0;
            if (frame_cnt == FR_LAST) begin
              state <= ST_SCALE;
            end else begin
              state    <= ST_CS_SETUP;
              adc_cs_n <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_SCALE: begin
          raw_hold  <= raw_comb;
          mv_hold   <= mv_comb;
          bcd_start <= 1'b1;
          state     <= ST_BCD;
        end

        ST_BCD: begin
          if (bcd_done) begin
            raw_avg   <= raw_hold;
            mv        <= mv_hold;
            ascii_out <= ascii_comb;
            out_valid <= 1'b1;
            state     <= ST_OUT_HOLD;
          end
        end

        ST_OUT_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cont_en) begin
              state     <= ST_CS_SETUP;
              adc_cs_n  <= 1'b0;
              cnt       <= '0;
              frame_cnt <= '0;
              acc       <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adc_voltmeter.sv
// Self-checking bench for serial_adc_voltmeter: ADC frame model, arithmetic
// result predictor, per-cycle output compare and SCLK/CS timing monitor.
`timescale 1ns/1ps
module tb_serial_adc_voltmeter;

  localparam int CLK_DIV     = 10;
  localparam int CONV_CYCLES = 40;
  localparam int PERIOD      = 10;
  localparam int VREF        = 5000;

  logic        clk, reset, start, cont_en, adc_sdo, out_ready;
  logic        adc_sclk, adc_cs_n, busy, out_valid;
  logic [7:0]  raw_avg;
  logic [13:0] mv;
  logic [31:0] ascii_out;

  serial_adc_voltmeter #(
    .DATA_W(8), .CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES),
    .AVG_LOG2(2), .VREF_MV(VREF)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cont_en(cont_en),
    .adc_sdo(adc_sdo), .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n),
    .busy(busy), .raw_avg(raw_avg), .mv(mv), .ascii_out(ascii_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0]  raw;
    logic [13:0] mv;
    logic [31:0] asc;
  } res_t;

  // Result the specification demands for one 5-frame run.
  function automatic res_t predict(input int codes[5]);
    res_t r;
    int sum, rv, m;
    sum = codes[1] + codes[2] + codes[3] + codes[4];
    rv  = sum / 4;
    m   = (rv * VREF) / 256;
    r.raw = 8'(rv);
    r.mv  = 14'(m);
    r.asc = {8'(48 + m / 1000), 8'(48 + (m / 100) % 10), 8'(48 + (m / 10) % 10), 8'(48 + m % 10)};
    return r;
  endfunction

  res_t       exp_q[$];
  logic [7:0] adc_q[$];
  logic [7:0] cur_code;
  int         bidx;
  int         served[5];
  int         nserved = 0;

  // ADC model: MSB appears when CS falls, later bits after each SCLK fall.
  always @(negedge adc_cs_n) begin
    if (reset === 1'b0) begin
      if (adc_q.size() > 0) cur_code = adc_q.pop_front();
      else                  cur_code = 8'h00;
      bidx    = 0;
      adc_sdo = cur_code[7];
      served[nserved] = int'(cur_code);
      nserved++;
      if (nserved == 5) begin
        exp_q.push_back(predict(served));
        nserved = 0;
      end
    end
  end

  always @(negedge adc_sclk) begin
    if (reset === 1'b0 && adc_cs_n === 1'b0 && bidx < 7) begin
      bidx++;
      adc_sdo = cur_code[7 - bidx];
    end
  end

  time t_cs, t_rise, t_high;
  bit  have_high = 1'b0;
  int  rises = 0;

  always @(posedge reset) begin
    nserved   = 0;
    exp_q.delete();
    have_high = 1'b0;
  end

  always @(negedge adc_cs_n) begin
    if (reset === 1'b0) begin
      if (have_high) begin
        checks++;
        if ((($time - t_high) / PERIOD) < CONV_CYCLES) begin
          errors++;
          $display("FAIL cs_high_gap: got %0d cycles required at least %0d",
                   ($time - t_high) / PERIOD, CONV_CYCLES);
        end
      end
      t_cs  = $time;
      rises = 0;
    end
  end

  always @(posedge adc_sclk) begin
    if (reset === 1'b0) begin
      rises++;
      chk("cs_low_at_rise", 32'(adc_cs_n), 32'd0);
      if (rises == 1) chk("sclk_first_rise", 32'(($time - t_cs) / PERIOD), 32'(CLK_DIV));
      else            chk("sclk_period", 32'(($time - t_rise) / PERIOD), 32'(2 * CLK_DIV));
      t_rise = $time;
    end
  end

  always @(posedge adc_cs_n) begin
    if (reset === 1'b0) begin
      chk("rises_per_frame", 32'(rises), 32'd8);
      t_high    = $time;
      have_high = 1'b1;
    end
  end

  bit prev_valid = 1'b0, prev_ready = 1'b0;

  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) chk("valid_held", 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: out_valid=1 with mv=%0d but no result expected", mv);
        end else begin
          chk("raw_avg", 32'(raw_avg), 32'(exp_q[0].raw));
          chk("mv", 32'(mv), 32'(exp_q[0].mv));
          chk("ascii_out", ascii_out, exp_q[0].asc);
        end
        chk("busy_in_hold", 32'(busy), 32'd1);
        chk("cs_n_in_hold", 32'(adc_cs_n), 32'd1);
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: out_valid stayed 0 for 5000 cycles, required 1", name);
  endtask

  task automatic handshake();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic push_n(input logic [7:0] code, input int n);
    for (int i = 0; i < n; i++) adc_q.push_back(code);
  endtask

  task automatic chk_result(input string tag, input logic [7:0] r, input logic [13:0] m,
                            input logic [31:0] a);
    chk({tag, "_raw"}, 32'(raw_avg), 32'(r));
    chk({tag, "_mv"}, 32'(mv), 32'(m));
    chk({tag, "_ascii"}, ascii_out, a);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cont_en = 1'b0; out_ready = 1'b0; adc_sdo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
    chk("rst_sclk", 32'(adc_sclk), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_raw", 32'(raw_avg), 32'd0);
    chk("rst_mv", 32'(mv), 32'd0);
    chk("rst_ascii", ascii_out, 32'h30303030);
    @(posedge clk); #1 reset = 1'b0;

    // out_ready while nothing is valid has no effect.
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    chk("idle_ready_valid", 32'(out_valid), 32'd0);
    chk("idle_ready_busy", 32'(busy), 32'd0);

    push_n(8'h80, 5);
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_cs_n", 32'(adc_cs_n), 32'd0);
    wait_valid("run_80");
    repeat (20) @(negedge clk);
    chk_result("run_80", 8'h80, 14'd2500, 32'h32353030);
    handshake();
    chk("run_80_busy_done", 32'(busy), 32'd0);
    chk("run_80_valid_done", 32'(out_valid), 32'd0);

    adc_q.push_back(8'hFF); adc_q.push_back(8'h00); adc_q.push_back(8'h01);
    adc_q.push_back(8'h02); adc_q.push_back(8'h03);
    pulse_start();
    wait_valid("run_seq");
    chk_result("run_seq", 8'h01, 14'd19, 32'h30303139);
    handshake();

    push_n(8'hFF, 5);
    pulse_start();
    repeat (300) @(posedge clk);
    pulse_start();
    wait_valid("run_ff");
    chk_result("run_ff", 8'hFF, 14'd4980, 32'h34393830);
    handshake();
    repeat (200) @(posedge clk);
    #1;
    chk("ignored_start_cs", 32'(adc_cs_n), 32'd1);
    chk("ignored_start_busy", 32'(busy), 32'd0);

    push_n(8'h00, 5);
    pulse_start();
    wait_valid("run_00");
    chk_result("run_00", 8'h00, 14'd0, 32'h30303030);
    handshake();

    // Continuous mode with a long consumer stall.
    push_n(8'h40, 5);
    push_n(8'h10, 5);
    @(posedge clk); #1 cont_en = 1'b1;
    wait_valid("cont_1");
    chk_result("cont_1", 8'h40, 14'd1250, 32'h31323530);
    for (int i = 0; i < 5; i++) begin
      repeat (1000) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    chk("stall_cs_n", 32'(adc_cs_n), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("cont_restart_cs", 32'(adc_cs_n), 32'd0);
    chk("cont_restart_busy", 32'(busy), 32'd1);
    chk("cont_restart_valid", 32'(out_valid), 32'd0);
    cont_en = 1'b0;
    wait_valid("cont_2");
    chk_result("cont_2", 8'h10, 14'd312, 32'h30333132);
    handshake();
    chk("cont_end_busy", 32'(busy), 32'd0);
    repeat (200) @(posedge clk);
    #1 chk("cont_end_cs", 32'(adc_cs_n), 32'd1);

    // Reset in the middle of a SHIFT phase.
    push_n(8'h80, 5);
    pulse_start();
    repeat (60) @(posedge clk);
    #2 chk("pre_reset_in_frame", 32'(adc_cs_n), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_cs_n", 32'(adc_cs_n), 32'd1);
    chk("mid_rst_sclk", 32'(adc_sclk), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    adc_q.delete();
    push_n(8'hC0, 5);
    pulse_start();
    wait_valid("post_rst");
    chk_result("post_rst", 8'hC0, 14'd3750, 32'h33373530);
    handshake();
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
